mod_timer_cmp: RTL and testbench

Memory-mapped 32-bit compare timer on the data bus.
- Programmable prescaler feeds a 32-bit up-counter, which is compared against COMPARE.
- A match sets a sticky status flag and emits a one-cycle interrupt pulse.
- The pulse drives the interrupt controller's i_timer input directly upstream. The controller ORs its inputs into a sticky status every cycle, so the timer must pulse, never hold a level.

---
 rtl/mod_timer_cmp_pkg.sv | 14 +
 rtl/tmr_prescaler.sv | 28 ++
 rtl/mod_timer_cmp.sv | 115 +++++++++++
 tb/tb_mod_timer_cmp.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_timer_cmp_pkg.sv
// Shared register offsets and CONTROL bit positions for the compare timer.
package mod_timer_cmp_pkg;

    localparam logic [31:0] TMR_COUNT    = 32'h0000_0000;
    localparam logic [31:0] TMR_COMPARE  = 32'h0000_0004;
    localparam logic [31:0] TMR_CONTROL  = 32'h0000_0008;
    localparam logic [31:0] TMR_STATUS   = 32'h0000_000c;
    localparam logic [31:0] TMR_PRESCALE = 32'h0000_0010;

    localparam int CTRL_EN = 0;
    localparam int CTRL_AR = 1;
    localparam int CTRL_IE = 2;

endpackage

// File: rtl/tmr_prescaler.sv
// Prescaler: divides the clock by (prescale+1) while enabled and emits tick.
module tmr_prescaler #(
    parameter int PRESCALE_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load_clear,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pre_cnt_reg;

    // A prescale reload restarts the division and suppresses the tick that cycle.
    assign tick = en && !load_clear && (pre_cnt_reg == prescale);

    always_ff @(negedge clk) begin
        if (rst) begin
            pre_cnt_reg <= '0;
        end else if (!en || load_clear || tick) begin
            pre_cnt_reg <= '0;
        end else begin
            pre_cnt_reg <= pre_cnt_reg + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/mod_timer_cmp.sv
// Memory-mapped 32-bit compare timer: prescaled up-counter, sticky match flag,
// one-cycle interrupt pulse. State changes on the falling edge like the rest of the data bus.
module mod_timer_cmp
    import mod_timer_cmp_pkg::*;
#(
    parameter int          PRESCALE_W    = 16,
    parameter logic [31:0] RESET_COMPARE = 32'hffff_ffff
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ie,
    input  logic        de,
    input  logic [31:0] iaddr,
    input  logic [31:0] daddr,
    input  logic [1:0]  drw,
    input  logic [31:0] din,
    output logic [31:0] iout,
    output logic [31:0] dout,
    output logic        i_timer
);

    logic [31:0]           count_reg;
    logic [31:0]           compare_reg;
    logic [2:0]            ctrl_reg;
    logic                  match_reg;
    logic [PRESCALE_W-1:0] prescale_reg;
    logic                  irq_reg;

    logic        wr;
    logic        wr_count, wr_compare, wr_control, wr_status, wr_prescale;
    logic        tick;
    logic [31:0] cnt_next;
    logic        match_event;
    logic        unused_bits;

    assign unused_bits = ^{ie, iaddr, drw[1]};

    assign wr          = de & drw[0];
    assign wr_count    = wr && (daddr == TMR_COUNT);
    assign wr_compare  = wr && (daddr == TMR_COMPARE);
    assign wr_control  = wr && (daddr == TMR_CONTROL);
    assign wr_status   = wr && (daddr == TMR_STATUS);
    assign wr_prescale = wr && (daddr == TMR_PRESCALE);

    tmr_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .clk       (clk),
        .rst       (rst),
        .en        (ctrl_reg[CTRL_EN]),
        .load_clear(wr_prescale),
        .prescale  (prescale_reg),
        .tick      (tick)
    );

    assign cnt_next = count_reg + 32'd1;
    // A software COUNT write overrides the tick, so no match is judged that cycle.
    assign match_event = tick && !wr_count && (cnt_next == compare_reg);

    always_ff @(negedge clk) begin
        if (rst) begin
            count_reg    <= '0;
            compare_reg  <= RESET_COMPARE;
            ctrl_reg     <= '0;
            match_reg    <= 1'b0;
            prescale_reg <= '0;
            irq_reg      <= 1'b0;
        end else begin
            if (wr_count) begin
                count_reg <= din;
            end else if (tick) begin
                count_reg <= (match_event && ctrl_reg[CTRL_AR]) ? 32'd0 : cnt_next;
            end

            if (wr_compare) begin
                compare_reg <= din;
            end

            // Software control writes win over the one-shot self-disable.
            if (wr_control) begin
                ctrl_reg <= din[2:0];
            end else if (match_event && !ctrl_reg[CTRL_AR]) begin
                ctrl_reg[CTRL_EN] <= 1'b0;
            end

            if (match_event) begin
                match_reg <= 1'b1;
            end else if (wr_status && din[0]) begin
                match_reg <= 1'b0;
            end

            if (wr_prescale) begin
                prescale_reg <= din[PRESCALE_W-1:0];
            end

            irq_reg <= match_event && ctrl_reg[CTRL_IE];
        end
    end

    always_comb begin
        dout = '0;
        case (daddr)
            TMR_COUNT:    dout = count_reg;
            TMR_COMPARE:  dout = compare_reg;
            TMR_CONTROL:  dout = {29'd0, ctrl_reg};
            TMR_STATUS:   dout = {31'd0, match_reg};
            TMR_PRESCALE: dout = 32'(prescale_reg);
            default:      dout = '0;
        endcase
    end

    assign iout    = '0;
    assign i_timer = irq_reg;

endmodule

// File: tb/tb_mod_timer_cmp.sv
// Directed bench for mod_timer_cmp: inputs change 1 time unit after each
// falling edge, outputs are checked there, reads are combinational.
module tb_mod_timer_cmp;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ie = 1'b0;
    logic        de = 1'b0;
    logic [31:0] iaddr = '0;
    logic [31:0] daddr = '0;
    logic [1:0]  drw = 2'b00;
    logic [31:0] din = '0;
    logic [31:0] iout;
    logic [31:0] dout;
    logic        i_timer;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] A_COUNT    = 32'h00;
    localparam logic [31:0] A_COMPARE  = 32'h04;
    localparam logic [31:0] A_CONTROL  = 32'h08;
    localparam logic [31:0] A_STATUS   = 32'h0c;
    localparam logic [31:0] A_PRESCALE = 32'h10;

    mod_timer_cmp dut (
        .clk    (clk),
        .rst    (rst),
        .ie     (ie),
        .de     (de),
        .iaddr  (iaddr),
        .daddr  (daddr),
        .drw    (drw),
        .din    (din),
        .iout   (iout),
        .dout   (dout),
        .i_timer(i_timer)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        de = 1'b1; drw = 2'b01; daddr = a; din = d;
        @(negedge clk);
        #1;
        drw = 2'b00; din = '0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        de = 1'b1; drw = 2'b00; daddr = a;
        #1;
        d = dout;
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++;
            if (i_timer !== 1'b0) begin
                n_err++; $display("FAIL reset_irq: got %b expected 0", i_timer);
            end
        end
        rst = 1'b0;
        bus_read(A_COUNT, v);    n_vec++;
        if (v !== 32'h0) begin n_err++; $display("FAIL reset_count: got %h expected 00000000", v); end
        bus_read(A_COMPARE, v);  n_vec++;
        if (v !== 32'hffffffff) begin n_err++; $display("FAIL reset_compare: got %h expected ffffffff", v); end
        bus_read(A_CONTROL, v);  n_vec++;
        if (v !== 32'h0) begin n_err++; $display("FAIL reset_control: got %h expected 00000000", v); end
        bus_read(A_STATUS, v);   n_vec++;
        if (v !== 32'h0) begin n_err++; $display("FAIL reset_status: got %h expected 00000000", v); end
        bus_read(A_PRESCALE, v); n_vec++;
        if (v !== 32'h0) begin n_err++; $display("FAIL reset_prescale: got %h expected 00000000", v); end
        bus_read(32'h14, v);     n_vec++;
        if (v !== 32'h0) begin n_err++; $display("FAIL unmapped_read: got %h expected 00000000", v); end
        n_vec++;
        if (iout !== 32'h0) begin n_err++; $display("FAIL iout_zero: got %h expected 00000000", iout); end
        $display("reset: registers checked after 2 reset cycles");
    endtask

    task automatic test_periodic();
        logic [31:0] v;
        logic [31:0] exp_cnt;
        logic        exp_irq;
        bus_write(A_PRESCALE, 32'd0);
        bus_write(A_COUNT, 32'd0);
        bus_write(A_COMPARE, 32'd5);
        bus_write(A_CONTROL, 32'b111);
        for (int k = 1; k <= 15; k++) begin
            step();
            exp_cnt = 32'(k % 5);
            exp_irq = ((k % 5) == 0);
            bus_read(A_COUNT, v); n_vec++;
            if (v !== exp_cnt) begin
                n_err++; $display("FAIL periodic_count[%0d]: got %h expected %h", k, v, exp_cnt);
            end
            n_vec++;
            if (i_timer !== exp_irq) begin
                n_err++; $display("FAIL periodic_irq[%0d]: got %b expected %b", k, i_timer, exp_irq);
            end
        end
        bus_read(A_STATUS, v); n_vec++;
        if (v !== 32'h1) begin n_err++; $display("FAIL periodic_status: got %h expected 00000001", v); end
        bus_write(A_CONTROL, 32'd0);
        bus_write(A_STATUS, 32'd1);
        bus_read(A_STATUS, v); n_vec++;
        if (v !== 32'h0) begin n_err++; $display("FAIL status_clear: got %h expected 00000000", v); end
        $display("periodic: compare=5 over 15 cycles, status clear");
    endtask

    task automatic test_prescaled_oneshot();
        logic [31:0] v;
        logic        exp_irq;
        bus_write(A_COUNT, 32'd0);
        bus_write(A_PRESCALE, 32'd3);
        bus_write(A_COMPARE, 32'd2);
        bus_write(A_CONTROL, 32'b101);
        for (int k = 1; k <= 58; k++) begin
            step();
            exp_irq = (k == 8);
            n_vec++;
            if (i_timer !== exp_irq) begin
                n_err++; $display("FAIL oneshot_irq[%0d]: got %b expected %b", k, i_timer, exp_irq);
            end
            if (k == 4) begin
                bus_read(A_COUNT, v); n_vec++;
                if (v !== 32'd1) begin n_err++; $display("FAIL oneshot_first_tick: got %h expected 00000001", v); end
            end
        end
        bus_read(A_COUNT, v);   n_vec++;
        if (v !== 32'd2) begin n_err++; $display("FAIL oneshot_count: got %h expected 00000002", v); end
        bus_read(A_CONTROL, v); n_vec++;
        if (v !== 32'b100) begin n_err++; $display("FAIL oneshot_control: got %h expected 00000004", v); end
        bus_read(A_STATUS, v);  n_vec++;
        if (v !== 32'd1) begin n_err++; $display("FAIL oneshot_status: got %h expected 00000001", v); end
        bus_read(A_PRESCALE, v); n_vec++;
        if (v !== 32'd3) begin n_err++; $display("FAIL prescale_read: got %h expected 00000003", v); end
        $display("prescaled one-shot: prescale=3 compare=2, single pulse then stop");
    endtask

    task automatic test_wrap();
        logic [31:0] v;
        logic [31:0] exp_seq [3];
        exp_seq[0] = 32'hffffffff; exp_seq[1] = 32'h0; exp_seq[2] = 32'h1;
        bus_write(A_CONTROL, 32'd0);
        bus_write(A_PRESCALE, 32'd0);
        bus_write(A_COMPARE, 32'd1);
        bus_write(A_STATUS, 32'd1);
        bus_write(A_COUNT, 32'hfffffffe);
        bus_write(A_CONTROL, 32'b001);
        for (int k = 0; k < 6; k++) begin
            step();
            bus_read(A_COUNT, v); n_vec++;
            if (v !== exp_seq[(k < 3) ? k : 2]) begin
                n_err++; $display("FAIL wrap_count[%0d]: got %h expected %h", k, v, exp_seq[(k < 3) ? k : 2]);
            end
            n_vec++;
            if (i_timer !== 1'b0) begin n_err++; $display("FAIL wrap_irq[%0d]: got %b expected 0", k, i_timer); end
        end
        bus_read(A_STATUS, v);  n_vec++;
        if (v !== 32'd1) begin n_err++; $display("FAIL wrap_status: got %h expected 00000001", v); end
        bus_read(A_CONTROL, v); n_vec++;
        if (v !== 32'd0) begin n_err++; $display("FAIL wrap_control: got %h expected 00000000", v); end
        $display("wrap: fffffffe -> ffffffff -> 0 -> 1 match, IE off");
    endtask

    task automatic test_collisions();
        logic [31:0] v;
        // STATUS clear on the match edge: match wins.
        bus_write(A_STATUS, 32'd1);
        bus_write(A_COUNT, 32'd0);
        bus_write(A_COMPARE, 32'd3);
        bus_write(A_CONTROL, 32'b111);
        bus_read(A_STATUS, v); n_vec++;
        if (v !== 32'd0) begin n_err++; $display("FAIL coll_status_pre: got %h expected 00000000", v); end
        step();
        step();
        bus_write(A_STATUS, 32'd1);
        bus_read(A_STATUS, v); n_vec++;
        if (v !== 32'd1) begin n_err++; $display("FAIL coll_status_match: got %h expected 00000001", v); end
        n_vec++;
        if (i_timer !== 1'b1) begin n_err++; $display("FAIL coll_status_irq: got %b expected 1", i_timer); end
        bus_read(A_COUNT, v); n_vec++;
        if (v !== 32'd0) begin n_err++; $display("FAIL coll_status_count: got %h expected 00000000", v); end
        bus_write(A_CONTROL, 32'd0);
        n_vec++;
        if (i_timer !== 1'b0) begin n_err++; $display("FAIL coll_irq_width: got %b expected 0", i_timer); end
        // COUNT write on a tick edge that would otherwise match.
        bus_write(A_STATUS, 32'd1);
        bus_write(A_COUNT, 32'd0);
        bus_write(A_CONTROL, 32'b001);
        step();
        step();
        bus_write(A_COUNT, 32'd100);
        bus_read(A_COUNT, v);   n_vec++;
        if (v !== 32'd100) begin n_err++; $display("FAIL coll_count_write: got %h expected 00000064", v); end
        bus_read(A_STATUS, v);  n_vec++;
        if (v !== 32'd0) begin n_err++; $display("FAIL coll_count_nomatch: got %h expected 00000000", v); end
        bus_read(A_CONTROL, v); n_vec++;
        if (v !== 32'd1) begin n_err++; $display("FAIL coll_count_en: got %h expected 00000001", v); end
        step();
        bus_read(A_COUNT, v);   n_vec++;
        if (v !== 32'd101) begin n_err++; $display("FAIL coll_count_next: got %h expected 00000065", v); end
        bus_write(A_CONTROL, 32'd0);
        $display("collisions: status-clear vs match, count write vs tick");
    endtask

    task automatic test_reset_mid();
        logic [31:0] v;
        bus_write(A_PRESCALE, 32'd0);
        bus_write(A_COUNT, 32'd0);
        bus_write(A_COMPARE, 32'd10);
        bus_write(A_STATUS, 32'd1);
        bus_write(A_CONTROL, 32'b111);
        for (int k = 0; k < 7; k++) step();
        bus_read(A_COUNT, v); n_vec++;
        if (v !== 32'd7) begin n_err++; $display("FAIL mid_pre_count: got %h expected 00000007", v); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_read(A_COUNT, v);    n_vec++;
        if (v !== 32'h0) begin n_err++; $display("FAIL mid_count: got %h expected 00000000", v); end
        bus_read(A_COMPARE, v);  n_vec++;
        if (v !== 32'hffffffff) begin n_err++; $display("FAIL mid_compare: got %h expected ffffffff", v); end
        bus_read(A_CONTROL, v);  n_vec++;
        if (v !== 32'h0) begin n_err++; $display("FAIL mid_control: got %h expected 00000000", v); end
        bus_read(A_STATUS, v);   n_vec++;
        if (v !== 32'h0) begin n_err++; $display("FAIL mid_status: got %h expected 00000000", v); end
        bus_read(A_PRESCALE, v); n_vec++;
        if (v !== 32'h0) begin n_err++; $display("FAIL mid_prescale: got %h expected 00000000", v); end
        for (int k = 0; k < 12; k++) begin
            n_vec++;
            if (i_timer !== 1'b0) begin n_err++; $display("FAIL mid_irq[%0d]: got %b expected 0", k, i_timer); end
            step();
        end
        bus_read(A_COUNT, v); n_vec++;
        if (v !== 32'h0) begin n_err++; $display("FAIL mid_count_idle: got %h expected 00000000", v); end
        $display("reset mid-count: reset at COUNT=7, timer stays idle");
    endtask

    initial begin
        test_reset();
        test_periodic();
        test_prescaled_oneshot();
        test_wrap();
        test_collisions();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
